// File: rtl/morty_wb_arbiter_if.sv
// Wishbone arbiter bus bundle: two masters and one shared slave.
// slave view is the arbiter; master view drives requests and slave replies.
interface morty_wb_arbiter_if;
  logic [31:0] if_addr_i;
  logic [3:0]  if_sel_i;
  logic        if_cyc_i;
  logic        if_stb_i;
  logic [31:0] if_dat_o;
  logic        if_ack_o;
  logic        if_err_o;

  logic [31:0] mem_addr_i;
  logic [31:0] mem_dat_i;
  logic [3:0]  mem_sel_i;
  logic        mem_cyc_i;
  logic        mem_stb_i;
  logic        mem_we_i;
  logic [31:0] mem_dat_o;
  logic        mem_ack_o;
  logic        mem_err_o;

  logic [31:0] wbm_addr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;

  logic [1:0]  grant_o;
  logic        timeout_o;

  modport slave (
    input  if_addr_i, if_sel_i, if_cyc_i, if_stb_i,
    output if_dat_o, if_ack_o, if_err_o,
    input  mem_addr_i, mem_dat_i, mem_sel_i,
    input  mem_cyc_i, mem_stb_i, mem_we_i,
    output mem_dat_o, mem_ack_o, mem_err_o,
    output wbm_addr_o, wbm_dat_o, wbm_sel_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i,
    output grant_o, timeout_o
  );

  modport master (
    output if_addr_i, if_sel_i, if_cyc_i, if_stb_i,
    input  if_dat_o, if_ack_o, if_err_o,
    output mem_addr_i, mem_dat_i, mem_sel_i,
    output mem_cyc_i, mem_stb_i, mem_we_i,
    input  mem_dat_o, mem_ack_o, mem_err_o,
    input  wbm_addr_o, wbm_dat_o, wbm_sel_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i,
    input  grant_o, timeout_o
  );
endinterface

// File: rtl/morty_wb_arbiter.sv
// Two-master Wishbone arbiter: MEM over IF, grant held for a whole cycle.
// A watchdog kills cycles the slave never answers.
module morty_wb_arbiter #(
  parameter int TIMEOUT = 255
) (
  input logic         clk_i,
  input logic         rst_i,
  morty_wb_arbiter_if.slave bus
);

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IF  = 2'd1,
    GNT_MEM = 2'd2
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [15:0] cnt;
  logic [15:0] cnt_n;

  logic [31:0] m_addr;
  logic [31:0] m_dat;
  logic [3:0]  m_sel;
  logic        m_cyc;
  logic        m_stb;
  logic        m_we;
  logic        own_cyc;
  logic        rsp_ack;
  logic        rsp_err;
  logic        expire;
  logic [1:0]  grant;

  logic [31:0] if_dat;
  logic        if_ack;
  logic        if_err;
  logic [31:0] mem_dat;
  logic        mem_ack;
  logic        mem_err;

  // State and watchdog registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Owner select, slave mux, response routing and next state
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    m_addr  = '0;
    m_dat   = '0;
    m_sel   = '0;
    m_cyc   = 1'b0;
    m_stb   = 1'b0;
    m_we    = 1'b0;
    own_cyc = 1'b0;
    rsp_ack = 1'b0;
    rsp_err = 1'b0;
    expire  = 1'b0;
    grant   = 2'b00;
    if_dat  = '0;
    if_ack  = 1'b0;
    if_err  = 1'b0;
    mem_dat = '0;
    mem_ack = 1'b0;
    mem_err = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (bus.mem_cyc_i) begin
          state_n = GNT_MEM;
        end else if (bus.if_cyc_i) begin
          state_n = GNT_IF;
        end
      end
      GNT_IF: begin
        grant   = 2'b01;
        own_cyc = bus.if_cyc_i;
        m_addr  = bus.if_addr_i;
        m_sel   = bus.if_sel_i;
        m_cyc   = bus.if_cyc_i;
        m_stb   = bus.if_stb_i;
      end
      GNT_MEM: begin
        grant   = 2'b10;
        own_cyc = bus.mem_cyc_i;
        m_addr  = bus.mem_addr_i;
        m_dat   = bus.mem_dat_i;
        m_sel   = bus.mem_sel_i;
        m_cyc   = bus.mem_cyc_i;
        m_stb   = bus.mem_stb_i;
        m_we    = bus.mem_we_i;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    if (state == GNT_IF || state == GNT_MEM) begin
      // err dominates a simultaneous ack
      rsp_err = bus.wbm_err_i;
      rsp_ack = bus.wbm_ack_i & ~bus.wbm_err_i;
      expire  = own_cyc & ~bus.wbm_ack_i &
                ~bus.wbm_err_i & (cnt == LAST);
      if (expire) begin
        m_cyc   = 1'b0;
        m_stb   = 1'b0;
        rsp_err = 1'b1;
      end
      if (rsp_ack || rsp_err || !own_cyc) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt + 16'd1;
      end
    end

    if (state == GNT_IF) begin
      if_dat = bus.wbm_dat_i;
      if_ack = rsp_ack;
      if_err = rsp_err;
    end
    if (state == GNT_MEM) begin
      mem_dat = bus.wbm_dat_i;
      mem_ack = rsp_ack;
      mem_err = rsp_err;
    end
  end

  assign bus.wbm_addr_o = m_addr;
  assign bus.wbm_dat_o  = m_dat;
  assign bus.wbm_sel_o  = m_sel;
  assign bus.wbm_cyc_o  = m_cyc;
  assign bus.wbm_stb_o  = m_stb;
  assign bus.wbm_we_o   = m_we;

  assign bus.if_dat_o   = if_dat;
  assign bus.if_ack_o   = if_ack;
  assign bus.if_err_o   = if_err;
  assign bus.mem_dat_o  = mem_dat;
  assign bus.mem_ack_o  = mem_ack;
  assign bus.mem_err_o  = mem_err;

  assign bus.grant_o    = grant;
  assign bus.timeout_o  = expire;

endmodule

// File: tb/tb_morty_wb_arbiter.sv
// Bench for morty_wb_arbiter: directed scenarios then random traffic.
// A transaction-level owner/age model predicts every output each cycle.
module tb_morty_wb_arbiter;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  morty_wb_arbiter_if bus ();

  morty_wb_arbiter #(.TIMEOUT(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // model: who owns the bus (0 none, 1 IF, 2 MEM) and cycles waited
  int owner = 0;
  int age   = 0;

  logic [1:0]  e_grant;
  logic        e_cyc, e_stb, e_we, e_to;
  logic [31:0] e_addr, e_wdat;
  logic [3:0]  e_sel;
  logic        e_if_ack, e_if_err, e_mem_ack, e_mem_err;
  logic [31:0] e_if_dat, e_mem_dat;
  logic        e_done;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    logic busy, rq_cyc, rq_stb;
    logic ack, err;
    e_grant = 2'b00; e_cyc = 0; e_stb = 0; e_we = 0;
    e_addr = 0; e_wdat = 0; e_sel = 0; e_to = 0;
    e_if_ack = 0; e_if_err = 0; e_if_dat = 0;
    e_mem_ack = 0; e_mem_err = 0; e_mem_dat = 0;
    e_done = 0;
    if (owner == 0) return;
    if (owner == 1) begin
      rq_cyc = bus.if_cyc_i; rq_stb = bus.if_stb_i;
      e_addr = bus.if_addr_i; e_sel = bus.if_sel_i;
      e_grant = 2'b01;
    end else begin
      rq_cyc = bus.mem_cyc_i; rq_stb = bus.mem_stb_i;
      e_addr = bus.mem_addr_i; e_sel = bus.mem_sel_i;
      e_wdat = bus.mem_dat_i; e_we = bus.mem_we_i;
      e_grant = 2'b10;
    end
    err = bus.wbm_err_i;
    ack = bus.wbm_ack_i && !err;
    busy = !bus.wbm_ack_i && !bus.wbm_err_i;
    e_to = rq_cyc && busy && (age == TO - 1);
    if (e_to) err = 1;
    e_cyc = rq_cyc && !e_to;
    e_stb = rq_stb && !e_to;
    if (owner == 1) begin
      e_if_ack = ack; e_if_err = err; e_if_dat = bus.wbm_dat_i;
    end else begin
      e_mem_ack = ack; e_mem_err = err; e_mem_dat = bus.wbm_dat_i;
    end
    e_done = ack || err || !rq_cyc;
  endtask

  task automatic model_step();
    if (rst) begin
      owner = 0; age = 0;
    end else if (owner == 0) begin
      age = 0;
      if (bus.mem_cyc_i) owner = 2;
      else if (bus.if_cyc_i) owner = 1;
    end else if (e_done) begin
      owner = 0; age = 0;
    end else begin
      age = age + 1;
    end
  endtask

  // inputs set at negedge; check mid-cycle, advance model at posedge
  task automatic cycle();
    #1;
    model_eval();
    check("grant", 64'(bus.grant_o), 64'(e_grant));
    check("wbm_ctl",
          64'({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o}),
          64'({e_cyc, e_stb, e_we, e_sel}));
    check("wbm_adr_dat", {bus.wbm_addr_o, bus.wbm_dat_o},
          {e_addr, e_wdat});
    check("if_rsp", 64'({bus.if_ack_o, bus.if_err_o, bus.if_dat_o}),
          64'({e_if_ack, e_if_err, e_if_dat}));
    check("mem_rsp", 64'({bus.mem_ack_o, bus.mem_err_o, bus.mem_dat_o}),
          64'({e_mem_ack, e_mem_err, e_mem_dat}));
    check("timeout", 64'(bus.timeout_o), 64'(e_to));
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.if_addr_i = 0; bus.if_sel_i = 0;
    bus.if_cyc_i = 0; bus.if_stb_i = 0;
    bus.mem_addr_i = 0; bus.mem_dat_i = 0; bus.mem_sel_i = 0;
    bus.mem_cyc_i = 0; bus.mem_stb_i = 0; bus.mem_we_i = 0;
    bus.wbm_dat_i = 0; bus.wbm_ack_i = 0; bus.wbm_err_i = 0;
  endtask

  task automatic if_req(input logic on);
    bus.if_cyc_i = on; bus.if_stb_i = on;
    bus.if_addr_i = 32'h40; bus.if_sel_i = 4'hF;
  endtask

  task automatic mem_req(input logic on, input logic we);
    bus.mem_cyc_i = on; bus.mem_stb_i = on; bus.mem_we_i = we;
    bus.mem_addr_i = 32'h100; bus.mem_dat_i = 32'h12345678;
    bus.mem_sel_i = 4'hF;
  endtask

  logic if_act, mem_act;

  initial begin
    idle_inputs();
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    cycle();
    rst = 0;
    #1;
    check("rst_grant", 64'(bus.grant_o), 64'd0);
    check("rst_cyc", 64'(bus.wbm_cyc_o), 64'd0);
    cycle();

    // single IF read
    if_req(1);
    cycle();
    #1; check("ifrd_g1", 64'(bus.grant_o), 64'h1);
    cycle();
    cycle();
    bus.wbm_ack_i = 1; bus.wbm_dat_i = 32'hDEADBEEF;
    #1; check("ifrd_ack", 64'({bus.if_ack_o, bus.if_dat_o}),
              64'({1'b1, 32'hDEADBEEF}));
    cycle();
    idle_inputs();
    #1; check("ifrd_g4", 64'(bus.grant_o), 64'h0);
    cycle();

    // simultaneous requests: MEM store first, then IF
    if_req(1); mem_req(1, 1);
    cycle();
    #1; check("sim_gmem", 64'(bus.grant_o), 64'h2);
    check("sw_bus", {bus.wbm_addr_o, bus.wbm_dat_o},
          {32'h100, 32'h12345678});
    check("sw_we", 64'(bus.wbm_we_o), 64'h1);
    cycle();
    bus.wbm_ack_i = 1;
    #1; check("sw_ack", 64'({bus.mem_ack_o, bus.if_ack_o}), 64'h2);
    cycle();
    bus.wbm_ack_i = 0; mem_req(0, 0);
    #1; check("turn_idle", 64'(bus.grant_o), 64'h0);
    cycle();
    #1; check("sim_gif", 64'(bus.grant_o), 64'h1);
    bus.wbm_ack_i = 1;
    cycle();
    idle_inputs();
    cycle();

    // watchdog on MEM with a dead slave
    mem_req(1, 0);
    cycle();
    for (int i = 0; i < TO - 1; i++) begin
      #1; check("wd_quiet", 64'(bus.timeout_o), 64'h0);
      cycle();
    end
    #1; check("wd_fire",
              64'({bus.timeout_o, bus.mem_err_o, bus.wbm_cyc_o}),
              64'({1'b1, 1'b1, 1'b0}));
    cycle();
    mem_req(0, 0);
    #1; check("wd_idle", 64'(bus.grant_o), 64'h0);
    cycle();

    // ack on final watchdog cycle is a normal ack
    mem_req(1, 0);
    cycle();
    for (int i = 0; i < TO - 1; i++) cycle();
    bus.wbm_ack_i = 1;
    #1; check("wd_lastack", 64'({bus.mem_ack_o, bus.timeout_o}), 64'h2);
    cycle();
    idle_inputs();
    cycle();

    // ack and err together
    if_req(1);
    cycle();
    bus.wbm_ack_i = 1; bus.wbm_err_i = 1;
    #1; check("ackerr", 64'({bus.if_ack_o, bus.if_err_o}), 64'h1);
    cycle();
    idle_inputs();
    cycle();

    // reset mid-transaction
    mem_req(1, 0);
    cycle();
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    #1; check("rst_mid",
              64'({bus.grant_o, bus.mem_ack_o, bus.wbm_cyc_o}), 64'h0);
    cycle();
    idle_inputs();
    bus.wbm_ack_i = 1;
    cycle();
    idle_inputs();
    cycle();

    // IF abort with MEM waiting
    if_req(1);
    cycle();
    if_req(0); mem_req(1, 1);
    #1; check("abort_cyc", 64'(bus.wbm_cyc_o), 64'h0);
    cycle();
    #1; check("abort_idle", 64'(bus.grant_o), 64'h0);
    cycle();
    #1; check("abort_gmem", 64'(bus.grant_o), 64'h2);
    bus.wbm_ack_i = 1;
    cycle();
    idle_inputs();
    cycle();

    // random traffic
    if_act = 0; mem_act = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!if_act && $urandom_range(0, 3) == 0) begin
        if_act = 1;
        bus.if_addr_i = $urandom; bus.if_sel_i = 4'($urandom);
      end else if (if_act && $urandom_range(0, 40) == 0) begin
        if_act = 0;
      end
      if (!mem_act && $urandom_range(0, 4) == 0) begin
        mem_act = 1;
        bus.mem_addr_i = $urandom; bus.mem_dat_i = $urandom;
        bus.mem_sel_i = 4'($urandom); bus.mem_we_i = 1'($urandom);
      end else if (mem_act && $urandom_range(0, 40) == 0) begin
        mem_act = 0;
      end
      bus.if_cyc_i = if_act;
      bus.if_stb_i = if_act;
      bus.mem_cyc_i = mem_act;
      bus.mem_stb_i = mem_act;
      bus.wbm_dat_i = $urandom;
      bus.wbm_ack_i = ($urandom_range(0, 3) == 0);
      bus.wbm_err_i = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 299) == 0);
      #1; model_eval();
      if (e_if_ack || e_if_err) if_act = 0;
      if (e_mem_ack || e_mem_err) mem_act = 0;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
